// File: rtl/convolution_engine_if.sv
// convolution_engine_if: operand/result bundle for convolution_engine.
// Master drives the lengths and vectors; slave returns the results and the done flag.
interface convolution_engine_if #(
    parameter int N = 16,
    parameter int M = 4
);
    logic [31:0]         len1;
    logic [31:0]         len2;
    logic [N*64-1:0]     x1;
    logic [M*64-1:0]     x2;
    logic [(N-M)*64-1:0] y;
    logic                done;
    modport master(output len1, x1, len2, x2, input y, done);
    modport slave(input len1, x1, len2, x2, output y, done);
endinterface

// File: rtl/convolution_engine.sv
// convolution_engine: sequential valid-mode 1-D binary64 convolution, one MAC per clock.
// Define CONVOLUTION_RESTART_EN to start a new pass on the edge after each DONE.
module convolution_engine #(
    parameter int N = 16,
    parameter int M = 4
) (
    input logic                  clk,
    input logic                  reset,
    convolution_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t              state;
    logic [31:0]         l1, l2, p, l2_r, p_r, cl2, cp, i, k, xi;
    logic [63:0]         acc, acc_next;
    logic [(N-M)*64-1:0] y;
    logic                done;
    assign l1 = bus.len1 > 32'(N) ? 32'(N) : bus.len1;
    assign l2 = bus.len2 > 32'(M) ? 32'(M) : bus.len2;
    assign p  = (l2 != 32'd0 && l1 > l2) ? ((l1 - l2 > 32'(N-M)) ? 32'(N-M) : l1 - l2) : 32'd0;
    // The IDLE edge both latches the lengths and performs the first MAC, so it uses them live
    assign cl2 = state == IDLE ? l2 : l2_r;
    assign cp  = state == IDLE ? p : p_r;
    assign xi  = i + cl2 - 32'd1 - k;
    assign acc_next = $realtobits($bitstoreal(acc) +
                      $bitstoreal(bus.x1[64*(N-1-xi) +: 64]) * $bitstoreal(bus.x2[64*(M-1-k) +: 64]));
    assign bus.y    = y;
    assign bus.done = done;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            y     <= '0;
            done  <= 1'b0;
            acc   <= '0;
            i     <= '0;
            k     <= '0;
            l2_r  <= '0;
            p_r   <= '0;
        end else if (state == DONE) begin
`ifdef CONVOLUTION_RESTART_EN
            state <= COMPUTE;
            done  <= 1'b0;
            l2_r  <= l2;
            p_r   <= p;
            acc   <= '0;
            i     <= '0;
            k     <= '0;
`else
            state <= DONE;
`endif
        end else begin
            if (state == IDLE) begin
                l2_r <= l2;
                p_r  <= p;
            end
            if (cp == 32'd0) begin
                state <= DONE;
                done  <= 1'b1;
            end else if (k == cl2 - 32'd1) begin
                y[64*(N-M-1-i) +: 64] <= acc_next;
                acc <= '0;
                k   <= '0;
                i   <= i + 32'd1;
                state <= (i == cp - 32'd1) ? DONE : COMPUTE;
                done  <= i == cp - 32'd1;
            end else begin
                acc   <= acc_next;
                k     <= k + 32'd1;
                state <= COMPUTE;
            end
        end
    end
endmodule

// File: tb/tb_convolution_engine.sv
// tb_convolution_engine: directed checks of convolution_engine with N=16, M=4.
module tb_convolution_engine;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    convolution_engine_if #(.N(16), .M(4)) bus();
    convolution_engine #(.N(16), .M(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input real got, input real exp);
        real d;
        d = got > exp ? got - exp : exp - got;
        checks++;
        if (!(d <= 1e-12)) begin
            errors++;
            $display("FAIL %s: got %g expected %g", tag, got, exp);
        end
    endtask
    function automatic real yv(input logic [767:0] v, input int i);
        return $bitstoreal(v[64*(11-i) +: 64]);
    endfunction
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask
    task automatic set_x2(input real a, input real b, input real c, input real d);
        bus.x2 = {$realtobits(a), $realtobits(b), $realtobits(c), $realtobits(d)};
    endtask
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.len1 = 32'd16;
        bus.len2 = 32'd4;
        for (int j = 0; j < 16; j++) bus.x1[64*(15-j) +: 64] = $realtobits(0.1 * (j + 1));
        set_x2(0.1, 0.2, 0.3, 0.4);
        #2;
        check("rst_done", real'(bus.done), 0.0);
        check("rst_y0", yv(bus.y, 0), 0.0);
        do_reset();
        tick(4);
        check("e4_y0", yv(bus.y, 0), 0.2);
        check("e4_y1", yv(bus.y, 1), 0.0);
        check("e4_y11", yv(bus.y, 11), 0.0);
        check("e4_done", real'(bus.done), 0.0);
        tick(4);
        check("e8_y1", yv(bus.y, 1), 0.3);
        check("e8_y2", yv(bus.y, 2), 0.0);
        tick(12);
        reset = 1'b0;
        #1;
        for (int j = 0; j < 12; j++) check($sformatf("async_rst_y%0d", j), yv(bus.y, j), 0.0);
        check("async_rst_done", real'(bus.done), 0.0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick(47);
        check("e47_done", real'(bus.done), 0.0);
        check("e47_y11", yv(bus.y, 11), 0.0);
        tick(1);
        check("e48_done", real'(bus.done), 1.0);
        for (int j = 0; j < 12; j++) check($sformatf("main_y%0d", j), yv(bus.y, j), 0.2 + 0.1 * j);
`ifdef CONVOLUTION_RESTART_EN
        set_x2(1.0, 1.0, 1.0, 1.0);
        tick(1);
        check("rs_e49_done", real'(bus.done), 0.0);
        check("rs_e49_y0", yv(bus.y, 0), 0.2);
        tick(47);
        check("rs_e96_done", real'(bus.done), 0.0);
        tick(1);
        check("rs_e97_done", real'(bus.done), 1.0);
        check("rs_y0", yv(bus.y, 0), 1.0);
        check("rs_y11", yv(bus.y, 11), 5.4);
        tick(1);
        check("rs_pulse", real'(bus.done), 0.0);
`else
        tick(52);
        check("hold_done", real'(bus.done), 1.0);
        check("hold_y0", yv(bus.y, 0), 0.2);
        check("hold_y11", yv(bus.y, 11), 1.3);
`endif
        bus.len2 = 32'd2;
        set_x2(1.0, 2.0, 9.0, 9.0);
        do_reset();
        tick(23);
        check("k2_e23_done", real'(bus.done), 0.0);
        tick(1);
        check("k2_e24_done", real'(bus.done), 1.0);
        for (int j = 0; j < 12; j++) check($sformatf("k2_y%0d", j), yv(bus.y, j), 0.3 * j + 0.4);
        bus.len1 = 32'd3;
        bus.len2 = 32'd4;
        set_x2(0.1, 0.2, 0.3, 0.4);
        do_reset();
        check("p0_pre_done", real'(bus.done), 0.0);
        tick(1);
        check("p0_done", real'(bus.done), 1.0);
        tick(5);
        for (int j = 0; j < 12; j++) check($sformatf("p0_y%0d", j), yv(bus.y, j), 0.0);
        bus.len1 = 32'd16;
        bus.len2 = 32'd0;
        do_reset();
        tick(1);
        check("l2z_done", real'(bus.done), 1.0);
        check("l2z_y0", yv(bus.y, 0), 0.0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
